// File: rtl/servo_pkg.sv
// Shared servo types, default timing/range constants and helpers for the ramp and PWM stages.
package servo_pkg;

  typedef logic [15:0] servo_width_t;

  localparam int DEF_CLK_HZ   = 50_000_000;
  localparam int DEF_FRAME_US = 20_000;
  localparam int DEF_MIN_US   = 1_000;
  localparam int DEF_MAX_US   = 2_000;
  localparam int DEF_RESET_US = 1_500;
  localparam int DEF_STEP_US  = 20;
  localparam int DEF_ACCEL_US = 5;

  typedef enum logic {
    IDLE = 1'b0,
    RAMP = 1'b1
  } ramp_state_t;

  // Clock cycles in a span of microseconds; clk_hz is assumed a whole number of MHz.
  function automatic int to_ticks(input int us, input int clk_hz);
    return us * (clk_hz / 1_000_000);
  endfunction

  function automatic servo_width_t clamp_us(input servo_width_t v,
                                            input servo_width_t lo,
                                            input servo_width_t hi);
    if (v < lo) return lo;
    if (v > hi) return hi;
    return v;
  endfunction

endpackage

// File: rtl/servo_frame_timer.sv
// Free-running servo frame timer: one-cycle tick every FRAME_US, shared by the ramp and PWM stages.
module servo_frame_timer
  import servo_pkg::*;
#(
  parameter int CLK_HZ   = DEF_CLK_HZ,
  parameter int FRAME_US = DEF_FRAME_US
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int            TICKS = to_ticks(FRAME_US, CLK_HZ);
  localparam int            CW    = (TICKS > 1) ? $clog2(TICKS) : 1;
  localparam logic [CW-1:0] LAST  = CW'(TICKS - 1);

  logic [CW-1:0] r_cnt;
  logic          w_last;

  assign w_last = (r_cnt == LAST);
  assign tick   = w_last;

  // NOTE: sequential state is always assigned with <= so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (w_last) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

endmodule

// File: rtl/servo_ramp.sv
// Slew-rate limiter feeding the servo PWM width; moves toward the clamped target once per frame.
// Optional soft-start easing is enabled with `define SERVO_RAMP_EASE_EN.
module servo_ramp
  import servo_pkg::*;
#(
  parameter int CLK_HZ   = DEF_CLK_HZ,
  parameter int FRAME_US = DEF_FRAME_US,
  parameter int MIN_US   = DEF_MIN_US,
  parameter int MAX_US   = DEF_MAX_US,
  parameter int RESET_US = DEF_RESET_US,
  parameter int STEP_US  = DEF_STEP_US
`ifdef SERVO_RAMP_EASE_EN
  ,
  parameter int ACCEL_US = DEF_ACCEL_US
`endif
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         target_valid,
  input  servo_width_t target_us,
  output logic         target_ready,
  output servo_width_t width_us,
  output logic         frame_tick,
  output logic         at_target,
  output logic         busy
);

  localparam servo_width_t MIN_W   = servo_width_t'(MIN_US);
  localparam servo_width_t MAX_W   = servo_width_t'(MAX_US);
  localparam servo_width_t RESET_W = servo_width_t'(RESET_US);
  localparam servo_width_t STEP_W  = servo_width_t'(STEP_US);

  ramp_state_t         r_state;
  ramp_state_t         w_state_next;
  servo_width_t        r_width;
  servo_width_t        r_target;
  servo_width_t        w_width_next;
  servo_width_t        w_clamped;
  servo_width_t        w_step;
  servo_width_t        w_mag;
  servo_width_t        w_delta;
  logic signed [16:0]  w_diff;
  logic                r_ready;
  logic                w_tick;
  logic                w_accept;

  servo_frame_timer #(
    .CLK_HZ  (CLK_HZ),
    .FRAME_US(FRAME_US)
  ) u_frame_timer (
    .clk (clk),
    .rst (rst),
    .tick(w_tick)
  );

  assign w_accept  = target_valid && r_ready;
  assign w_clamped = clamp_us(target_us, MIN_W, MAX_W);

  // Signed distance to the stored target; its sign picks the direction, the step never overshoots.
  assign w_diff  = $signed({1'b0, r_target}) - $signed({1'b0, r_width});
  assign w_mag   = w_diff[16] ? servo_width_t'(-w_diff) : servo_width_t'(w_diff);
  assign w_delta = (w_mag < w_step) ? w_mag : w_step;

`ifdef SERVO_RAMP_EASE_EN
  localparam servo_width_t ACCEL_W = servo_width_t'(ACCEL_US);

  servo_width_t r_step;
  logic [16:0]  w_step_sum;

  assign w_step_sum = {1'b0, r_step} + {1'b0, ACCEL_W};
  assign w_step     = r_step;

  // Every accept restarts the soft start; each ramp tick grows the step up to STEP_US.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_step <= ACCEL_W;
    end else if (w_accept) begin
      r_step <= ACCEL_W;
    end else if ((r_state == RAMP) && w_tick) begin
      r_step <= (w_step_sum > {1'b0, STEP_W}) ? STEP_W : w_step_sum[15:0];
    end else if (r_state == IDLE) begin
      r_step <= ACCEL_W;
    end
  end
`else
  assign w_step = STEP_W;
`endif

  // NOTE: every always_comb output gets a default first so no path leaves a latch behind.
  always_comb begin
    w_width_next = r_width;
    w_state_next = r_state;

    if ((r_state == RAMP) && w_tick) begin
      w_width_next = w_diff[16] ? (r_width - w_delta) : (r_width + w_delta);
    end

    unique case (r_state)
      IDLE: begin
        if (w_accept && (w_clamped != r_width)) begin
          w_state_next = RAMP;
        end
      end
      RAMP: begin
        // A fresh target decides the state against the width this edge produces.
        if (w_accept) begin
          w_state_next = (w_clamped == w_width_next) ? IDLE : RAMP;
        end else if (w_tick && (w_width_next == r_target)) begin
          w_state_next = IDLE;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= IDLE;
      r_width  <= RESET_W;
      r_target <= RESET_W;
      r_ready  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_width <= w_width_next;
      r_ready <= 1'b1;
      if (w_accept) begin
        r_target <= w_clamped;
      end
    end
  end

  assign target_ready = r_ready;
  assign width_us     = r_width;
  assign frame_tick   = w_tick;
  assign at_target    = (r_width == r_target);
  assign busy         = ~at_target;

endmodule

// File: tb/tb_servo_ramp.sv
// Self-checking bench for servo_ramp: per-cycle reference model plus directed literal scenarios.
module tb_servo_ramp;

  localparam int TB_CLK_HZ   = 1_000_000;
  localparam int TB_FRAME_US = 24;
  localparam int FT          = TB_FRAME_US * (TB_CLK_HZ / 1_000_000);
  localparam int MIN_V       = 1000;
  localparam int MAX_V       = 2000;
  localparam int RST_V       = 1500;
  localparam int STEP_V      = 20;
  localparam int ACCEL_V     = 5;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        target_valid = 1'b0;
  logic [15:0] target_us = 16'd0;
  logic        target_ready;
  logic [15:0] width_us;
  logic        frame_tick;
  logic        at_target;
  logic        busy;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  servo_ramp #(
    .CLK_HZ  (TB_CLK_HZ),
    .FRAME_US(TB_FRAME_US),
    .MIN_US  (MIN_V),
    .MAX_US  (MAX_V),
    .RESET_US(RST_V),
    .STEP_US (STEP_V)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .target_valid(target_valid),
    .target_us   (target_us),
    .target_ready(target_ready),
    .width_us    (width_us),
    .frame_tick  (frame_tick),
    .at_target   (at_target),
    .busy        (busy)
  );

  // Reference model: the frame phase counts cycles since reset, the width walks toward the target.
  int m_phase, m_width, m_target, m_step;
  bit m_ready, m_live;
  int w, t, s, d;
  bit tk, acc;

  always @(posedge clk) begin
    m_live <= 1'b1;
    if (rst) begin
      m_phase  <= 0;
      m_width  <= RST_V;
      m_target <= RST_V;
      m_step   <= ACCEL_V;
      m_ready  <= 1'b0;
    end else begin
      w   = m_width;
      t   = m_target;
      tk  = (m_phase == FT - 1);
      acc = target_valid && m_ready;
`ifdef SERVO_RAMP_EASE_EN
      s = m_step;
`else
      s = STEP_V;
`endif
      if (tk && (w != t)) begin
        d = (t > w) ? t - w : w - t;
        if (d > s) d = s;
        w = (t > w) ? w + d : w - d;
      end
      if (acc) m_step <= ACCEL_V;
      else if (tk && (m_width != m_target)) m_step <= (m_step + ACCEL_V > STEP_V) ? STEP_V : m_step + ACCEL_V;
      if (acc) t = (int'(target_us) < MIN_V) ? MIN_V : (int'(target_us) > MAX_V) ? MAX_V : int'(target_us);
      m_width  <= w;
      m_target <= t;
      m_phase  <= (m_phase + 1) % FT;
      m_ready  <= 1'b1;
    end
  end

  always @(negedge clk) begin
    if (m_live) begin
      n_tests++;
      if (width_us !== 16'(m_width) || frame_tick !== (m_phase == FT - 1) ||
          at_target !== (m_width == m_target) || busy !== (m_width != m_target) ||
          target_ready !== m_ready) begin
        n_fail++;
        $display("FAIL cycle_compare t=%0t: width=%0d tick=%b at=%b busy=%b ready=%b, expected width=%0d tick=%b at=%b busy=%b ready=%b",
                 $time, width_us, frame_tick, at_target, busy, target_ready,
                 m_width, (m_phase == FT - 1), (m_width == m_target), (m_width != m_target), m_ready);
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic send(input int v);
    @(negedge clk);
    target_valid = 1'b1;
    target_us    = 16'(v);
    @(negedge clk);
    target_valid = 1'b0;
  endtask

  task automatic wait_tick();
    int k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (frame_tick !== 1'b1 && k < FT + 2);
    check("tick_seen", 32'(frame_tick), 32'd1);
  endtask

  task automatic next_width(output int wv);
    wait_tick();
    @(negedge clk);
    wv = int'(width_us);
  endtask

  task automatic settle(output int n);
    int wv;
    n = 0;
    while (at_target !== 1'b1 && n < 80) begin
      next_width(wv);
      n++;
    end
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("rst_width", 32'(width_us), 32'd1500);
    check("rst_at_target", 32'(at_target), 32'd1);
    check("rst_ready", 32'(target_ready), 32'd0);
    rst = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int k, n, wv, r;
    int exp_w[$];

    // Reset values and first frame tick.
    repeat (3) @(negedge clk);
    check("reset_width", 32'(width_us), 32'd1500);
    check("reset_at_target", 32'(at_target), 32'd1);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_ready", 32'(target_ready), 32'd0);
    check("reset_tick", 32'(frame_tick), 32'd0);
    rst = 1'b0;
    k = 0;
    do begin
      @(negedge clk);
      k++;
      if (k == 1) check("ready_after_release", 32'(target_ready), 32'd1);
    end while (frame_tick !== 1'b1 && k < FT + 2);
    check("first_tick_cycle", 32'(k), 32'(FT - 1));

`ifdef SERVO_RAMP_EASE_EN
    // Soft start toward 1600.
    send(1600);
    check("ease_at_target_drop", 32'(at_target), 32'd0);
    exp_w = '{1505, 1515, 1530, 1550, 1570, 1590, 1600};
    foreach (exp_w[i]) begin
      next_width(wv);
      check($sformatf("ease_width_%0d", i), 32'(wv), 32'(exp_w[i]));
    end
    check("ease_at_target_end", 32'(at_target), 32'd1);
`else
    // Plain ramp to 1600.
    send(1600);
    check("up_at_target_drop", 32'(at_target), 32'd0);
    exp_w = '{1520, 1540, 1560, 1580, 1600};
    foreach (exp_w[i]) begin
      next_width(wv);
      check($sformatf("up_width_%0d", i), 32'(wv), 32'(exp_w[i]));
      if (i < 4) check($sformatf("up_busy_%0d", i), 32'(busy), 32'd1);
    end
    check("up_at_target_end", 32'(at_target), 32'd1);
    check("model_pin_1600", 32'(m_width), 32'd1600);

    // Clamping at both ends.
    pulse_reset();
    send(500);
    check("low_at_target_drop", 32'(at_target), 32'd0);
    settle(n);
    check("low_tick_count", 32'(n), 32'd25);
    check("low_width", 32'(width_us), 32'd1000);
    check("model_pin_low", 32'(m_target), 32'd1000);
    send(2500);
    settle(n);
    check("high_tick_count", 32'(n), 32'd50);
    check("high_width", 32'(width_us), 32'd2000);

    // Short move lands exactly; equal target stays idle.
    send(1500);
    settle(n);
    send(1510);
    next_width(wv);
    check("short_width", 32'(wv), 32'd1510);
    check("short_at_target", 32'(at_target), 32'd1);
    send(1500);
    settle(n);
    send(1500);
    check("same_at_target", 32'(at_target), 32'd1);
    next_width(wv);
    check("same_width", 32'(wv), 32'd1500);
    check("same_busy", 32'(busy), 32'd0);

    // Accept on a tick edge steps toward the old target, then reverses.
    send(1600);
    next_width(wv);
    check("rev_w0", 32'(wv), 32'd1520);
    next_width(wv);
    check("rev_w1", 32'(wv), 32'd1540);
    wait_tick();
    target_valid = 1'b1;
    target_us    = 16'd1400;
    @(negedge clk);
    target_valid = 1'b0;
    check("rev_tick_edge", 32'(width_us), 32'd1560);
    check("rev_busy", 32'(busy), 32'd1);
    next_width(wv);
    check("rev_w2", 32'(wv), 32'd1540);
    next_width(wv);
    check("rev_w3", 32'(wv), 32'd1520);
    pulse_reset();
`endif

    // Randomized traffic, occasional resets, out-of-range values.
    for (int c = 0; c < 15000; c++) begin
      @(negedge clk);
      rst          = ($urandom_range(0, 4999) == 0);
      target_valid = ($urandom_range(0, 79) == 0);
      r = $urandom_range(0, 3);
      case (r)
        0:       target_us = 16'($urandom_range(0, 65535));
        1:       target_us = 16'($urandom_range(900, 2100));
        2:       target_us = 16'($urandom_range(0, 2) == 0 ? MIN_V : ($urandom_range(0, 1) == 0 ? MAX_V : RST_V));
        default: target_us = 16'(m_width + $urandom_range(0, 60) - 30);
      endcase
    end
    @(negedge clk);
    rst          = 1'b0;
    target_valid = 1'b0;
    repeat (4) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
